mcpu_ps2_kbd: RTL and testbench

// - PS/2 keyboard receiver: produces the 8-bit keycode the mcpu SoC consumes on its ALU Y input.
// - Deserialises device-clocked PS/2 frames, folds E0/F0 prefixes into flags and buffers scancodes in a small FIFO.
// - CPU polls key_valid/keycode and pops with key_pop; replaces the raw keycode pin in the top level.

---
 rtl/mcpu_ps2_kbd_pkg.sv | 35 +++
 rtl/mcpu_ps2_kbd_fifo.sv | 60 ++++++
 rtl/mcpu_ps2_kbd.sv | 197 +++++++++++++++++++
 tb/tb_mcpu_ps2_kbd.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_ps2_kbd_pkg.sv
// ============================================================================
// Module   : mcpu_ps2_kbd_pkg
// Brief    : Shared types and constants for the mcpu PS/2 keyboard receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mcpu_ps2_kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_CODE_EXT = 8'hE0;
  localparam logic [7:0] PS2_CODE_BRK = 8'hF0;
  localparam int         CODE_W       = 8;
  localparam int         ENTRY_W      = CODE_W + 2;

  typedef struct packed {
    logic              ext;
    logic              rel;
    logic [CODE_W-1:0] code;
  } ps2_entry_t;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [CODE_W-1:0] code, input logic par);
    return ^{code, par};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mcpu_ps2_kbd_fifo.sv
// ============================================================================
// Module   : mcpu_ps2_kbd_fifo
// Brief    : Show-ahead FIFO; head is presented from registered storage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcpu_ps2_kbd_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot in the same cycle, so a full FIFO still takes the push.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/mcpu_ps2_kbd.sv
// ============================================================================
// Module   : mcpu_ps2_kbd
// Brief    : PS/2 keyboard receiver feeding scancodes to the mcpu CPU.
//            MCPU_PS2_TIMEOUT_EN enables the mid-frame idle timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcpu_ps2_kbd
  import mcpu_ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int FILTER_LEN     = 8
`ifdef MCPU_PS2_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 50000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       key_pop,
  input  logic       err_clr,
  output logic [7:0] keycode,
  output logic       key_valid,
  output logic       key_ext,
  output logic       key_rel,
  output logic       frame_err,
  output logic       ovf_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);

  logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic           filt_q;
  logic [FCW-1:0] filt_cnt_q;
  logic           filt_take, edge_any, edge_fall;

  ps2_state_e     state_q, state_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           par_q, par_d;
  logic           ext_pend_q, ext_pend_d, rel_pend_q, rel_pend_d;
  logic           frame_err_q, ovf_err_q;
  logic           push, frame_bad, timeout;

  ps2_entry_t     head;
  logic           fifo_empty, fifo_full;

  // A new ps2_clk level is taken once it has differed for FILTER_LEN samples.
  assign filt_take = (clk_s2_q != filt_q) && (filt_cnt_q == FCW'(FILTER_LEN - 1));
  assign edge_any  = filt_take;
  assign edge_fall = filt_take && filt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
      if (clk_s2_q == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_take) begin
        filt_q     <= clk_s2_q;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end
  end

`ifdef MCPU_PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;

  assign timeout = (state_q != ST_IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset || edge_any || state_q == ST_IDLE) begin
      tmo_q <= '0;
    end else if (!timeout) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    ext_pend_d = ext_pend_q;
    rel_pend_d = rel_pend_q;
    push       = 1'b0;
    frame_bad  = 1'b0;
    if (edge_fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!dat_s2_q) begin
            state_d  = ST_DATA;
            bitcnt_d = 3'd0;
          end else begin
            frame_bad = 1'b1;
          end
        end
        ST_DATA: begin
          shreg_d = {dat_s2_q, shreg_q[7:1]};
          if (bitcnt_q == 3'd7) state_d = ST_PARITY;
          else                  bitcnt_d = bitcnt_q + 3'd1;
        end
        ST_PARITY: begin
          par_d   = dat_s2_q;
          state_d = ST_STOP;
        end
        default: begin
          state_d = ST_IDLE;
          if (dat_s2_q && odd_parity_ok(shreg_q, par_q)) begin
            if (shreg_q == PS2_CODE_EXT) begin
              ext_pend_d = 1'b1;
            end else if (shreg_q == PS2_CODE_BRK) begin
              rel_pend_d = 1'b1;
            end else begin
              push       = 1'b1;
              ext_pend_d = 1'b0;
              rel_pend_d = 1'b0;
            end
          end else begin
            frame_bad  = 1'b1;
            ext_pend_d = 1'b0;
            rel_pend_d = 1'b0;
          end
        end
      endcase
    end else if (timeout) begin
      // Prefixes survive a timeout so the key that follows keeps its E0/F0.
      state_d   = ST_IDLE;
      bitcnt_d  = 3'd0;
      frame_bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= 3'd0;
      shreg_q     <= 8'h00;
      par_q       <= 1'b0;
      ext_pend_q  <= 1'b0;
      rel_pend_q  <= 1'b0;
      frame_err_q <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      ext_pend_q  <= ext_pend_d;
      rel_pend_q  <= rel_pend_d;
      frame_err_q <= frame_bad | (frame_err_q & ~err_clr);
      ovf_err_q   <= (push & fifo_full & ~key_pop) | (ovf_err_q & ~err_clr);
    end
  end

  mcpu_ps2_kbd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i ({ext_pend_q, rel_pend_q, shreg_q}),
    .pop_i   (key_pop),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign key_valid = !fifo_empty;
  assign keycode   = fifo_empty ? 8'h00 : head.code;
  assign key_ext   = !fifo_empty && head.ext;
  assign key_rel   = !fifo_empty && head.rel;
  assign frame_err = frame_err_q;
  assign ovf_err   = ovf_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mcpu_ps2_kbd.sv
// ============================================================================
// Module   : tb_mcpu_ps2_kbd
// Brief    : Self-checking bench with a queue-based reference model.
//            MCPU_PS2_TIMEOUT_EN adds the timeout scenario.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcpu_ps2_kbd;

  localparam int DEPTH = 4;
  localparam int FLEN  = 8;
  localparam int TMO   = 300;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_pop = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] keycode;
  logic       key_valid, key_ext, key_rel, frame_err, ovf_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0] mq[$];
  bit m_ext, m_rel, m_ferr, m_ovf;

  always #5 clk = ~clk;

  mcpu_ps2_kbd #(
    .FIFO_DEPTH (DEPTH),
    .FILTER_LEN (FLEN)
`ifdef MCPU_PS2_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (TMO)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_pop   (key_pop),
    .err_clr   (err_clr),
    .keycode   (keycode),
    .key_valid (key_valid),
    .key_ext   (key_ext),
    .key_rel   (key_rel),
    .frame_err (frame_err),
    .ovf_err   (ovf_err)
  );

  // {valid, ext, rel, keycode, frame_err, ovf_err}
  function automatic logic [12:0] model_exp();
    logic [9:0] h;
    if (mq.size() == 0) return {11'd0, m_ferr, m_ovf};
    h = mq[0];
    return {1'b1, h[9], h[8], h[7:0], m_ferr, m_ovf};
  endfunction

  function automatic void model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      m_ferr = 1; m_ext = 0; m_rel = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_rel = 1;
    end else begin
      if (mq.size() < DEPTH) mq.push_back({m_ext, m_rel, b});
      else m_ovf = 1;
      m_ext = 0; m_rel = 0;
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_ext = 0; m_rel = 0; m_ferr = 0; m_ovf = 0;
  endfunction

  function automatic logic [12:0] obs();
    return {key_valid, key_ext, key_rel, keycode, frame_err, ovf_err};
  endfunction

  task automatic ps2_bit(input logic d);
    @(negedge clk) ps2_data = d;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic [10:0] f;
    f = {1'b1, ~(^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    repeat (5) @(negedge clk);
    model_frame(b, !bad_par);
  endtask

  task automatic do_pop();
    @(negedge clk) key_pop = 1'b1;
    @(negedge clk) key_pop = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic do_clr();
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    m_ferr = 0; m_ovf = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk) reset = 1'b1;
    ps2_clk = 1'b1; ps2_data = 1'b1; key_pop = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (obs() !== 13'd0) begin
      n_errors++; $display("FAIL reset: got %h want %h", obs(), 13'd0);
    end
  endtask

  task automatic test_single();
    send_frame(8'h1C, 0);
    n_checks++;
    if (obs() !== model_exp() || keycode !== 8'h1C) begin
      n_errors++; $display("FAIL single_1C: got %h want %h", obs(), model_exp());
    end
    do_pop();
    n_checks++;
    if (key_valid !== 1'b0 || keycode !== 8'h00) begin
      n_errors++; $display("FAIL single_pop: got valid=%b code=%h want 0 00", key_valid, keycode);
    end
  endtask

  task automatic test_prefix();
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    n_checks++;
    if (key_valid !== 1'b0) begin
      n_errors++; $display("FAIL prefix_no_entry: got valid=%b want 0", key_valid);
    end
    send_frame(8'h75, 0);
    n_checks++;
    if (obs() !== model_exp() || obs() !== {3'b111, 8'h75, 2'b00}) begin
      n_errors++; $display("FAIL prefix_75: got %h want %h", obs(), model_exp());
    end
    do_pop();
    n_checks++;
    if (key_valid !== 1'b0) begin
      n_errors++; $display("FAIL prefix_one_entry: got valid=%b want 0", key_valid);
    end
  endtask

  task automatic test_parity_err();
    send_frame(8'h1C, 1);
    n_checks++;
    if (obs() !== model_exp() || frame_err !== 1'b1 || key_valid !== 1'b0) begin
      n_errors++; $display("FAIL parity_err: got %h want %h", obs(), model_exp());
    end
    do_clr();
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_errors++; $display("FAIL err_clr: got frame_err=%b want 0", frame_err);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] want;
    apply_reset();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 0);
    n_checks++;
    if (obs() !== model_exp() || ovf_err !== 1'b1 || keycode !== 8'h01) begin
      n_errors++; $display("FAIL ovf_set: got %h want %h", obs(), model_exp());
    end
    do_clr();
    // Full FIFO: pop lands on the same cycle the stop-bit edge pushes 05.
    for (int i = 0; i < 10; i++) ps2_bit(i == 0 ? 1'b0 : (i == 9 ? ~(^8'h05) : 1'((8'h05 >> (i - 1)) & 1)));
    @(negedge clk) ps2_data = 1'b1;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (9) @(negedge clk);
    key_pop = 1'b1;
    @(negedge clk) key_pop = 1'b0;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (15) @(negedge clk);
    void'(mq.pop_front());
    model_frame(8'h05, 1);
    n_checks++;
    if (obs() !== model_exp() || ovf_err !== 1'b0) begin
      n_errors++; $display("FAIL push_pop_full: got %h want %h", obs(), model_exp());
    end
    for (int i = 0; i < DEPTH; i++) begin
      want = 8'(i + 2);
      n_checks++;
      if (keycode !== want || key_valid !== 1'b1) begin
        n_errors++; $display("FAIL drain_%0d: got %h want %h", i, keycode, want);
      end
      do_pop();
    end
    n_checks++;
    if (key_valid !== 1'b0) begin
      n_errors++; $display("FAIL drain_empty: got valid=%b want 0", key_valid);
    end
  endtask

  task automatic test_glitch();
    @(negedge clk) ps2_data = 1'b0;
    ps2_clk = 1'b0;
    @(negedge clk) ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (obs() !== model_exp()) begin
      n_errors++; $display("FAIL glitch_ignored: got %h want %h", obs(), model_exp());
    end
    send_frame(8'h33, 0);
    n_checks++;
    if (obs() !== model_exp() || keycode !== 8'h33) begin
      n_errors++; $display("FAIL glitch_then_33: got %h want %h", obs(), model_exp());
    end
    do_pop();
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h12, 0);
    send_frame(8'hE0, 0);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    apply_reset();
    n_checks++;
    if (obs() !== 13'd0) begin
      n_errors++; $display("FAIL reset_midframe: got %h want %h", obs(), 13'd0);
    end
    send_frame(8'h15, 0);
    n_checks++;
    if (obs() !== model_exp() || key_ext !== 1'b0) begin
      n_errors++; $display("FAIL after_reset_15: got %h want %h", obs(), model_exp());
    end
    do_pop();
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit bad;
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 9))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        default: b = 8'($urandom_range(1, 8'h7F));
      endcase
      bad = ($urandom_range(0, 7) == 0);
      send_frame(b, bad);
      n_checks++;
      if (obs() !== model_exp()) begin
        n_errors++; $display("FAIL random_%0d byte=%h bad=%0d: got %h want %h", n, b, bad, obs(), model_exp());
      end
      if ($urandom_range(0, 2) == 0) do_pop();
      if ($urandom_range(0, 5) == 0) do_clr();
    end
    n_checks++;
    if (obs() !== model_exp()) begin
      n_errors++; $display("FAIL random_end: got %h want %h", obs(), model_exp());
    end
  endtask

`ifdef MCPU_PS2_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    send_frame(8'hE0, 0);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TMO + 50) @(negedge clk);
    m_ferr = 1;
    n_checks++;
    if (obs() !== model_exp() || frame_err !== 1'b1) begin
      n_errors++; $display("FAIL timeout: got %h want %h", obs(), model_exp());
    end
    do_clr();
    send_frame(8'h2A, 0);
    n_checks++;
    if (obs() !== model_exp() || keycode !== 8'h2A || key_ext !== 1'b1) begin
      n_errors++; $display("FAIL timeout_then_2A: got %h want %h", obs(), model_exp());
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_prefix();
    test_parity_err();
    test_glitch();
    test_overflow();
    test_reset_midframe();
    test_random();
`ifdef MCPU_PS2_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
